// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one partial product per BUSY cycle,
// WIDTH BUSY cycles per operation, result presented with a one-cycle o_valid pulse.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 i_valid,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 o_valid,
    output logic [1:0]           fsm_state
);

    // Handshake: a request transfers on a rising edge where i_valid and ready are
    // both 1; i_valid while ready is 0 is dropped, never queued. o_valid is a
    // one-cycle pulse with no backpressure.

    localparam int CW = (WIDTH < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   next_acc;

    always_comb begin
        addend = '0;
        if (mplier[0]) begin
            addend = {{WIDTH{1'b0}}, mcand} << count;
        end
        next_acc = acc + addend;
    end

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ready   <= 1'b1;
            o_valid <= 1'b0;
            P       <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && ready) begin
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        count  <= '0;
                        ready  <= 1'b0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // Fixed WIDTH iterations even when mplier runs out of ones early.
                    acc    <= next_acc;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    if (count == LAST) begin
                        P       <= next_acc;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    o_valid <= 1'b0;
                    ready   <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    o_valid <= 1'b0;
                    ready   <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier at WIDTH 4, 8 and 1: a timeline reference model checks
// the WIDTH=4 instance every cycle, directed requests pin literal results and latency.
module tb_seq_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  a4 = '0, b4 = '0;
    logic        v4 = 1'b0, r4, ov4;
    logic [7:0]  p4;
    logic [1:0]  st4;

    logic [7:0]  a8 = '0, b8 = '0;
    logic        v8 = 1'b0, r8, ov8;
    logic [15:0] p8;
    logic [1:0]  st8;

    logic [0:0]  a1 = '0, b1 = '0;
    logic        v1 = 1'b0, r1, ov1;
    logic [1:0]  p1;
    logic [1:0]  st1;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .i_valid(v4),
        .ready(r4), .P(p4), .o_valid(ov4), .fsm_state(st4)
    );
    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .i_valid(v8),
        .ready(r8), .P(p8), .o_valid(ov8), .fsm_state(st8)
    );
    seq_multiplier #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .i_valid(v1),
        .ready(r1), .P(p1), .o_valid(ov1), .fsm_state(st1)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    // Reference model for the WIDTH=4 instance: cycles elapsed since accept.
    // -1 idle; 0..3 computing; 4 result cycle; product appears on entry to 4.
    int         m_since = -1;
    logic [7:0] m_pend  = '0;
    logic [7:0] m_p     = '0;
    bit         m_live  = 1'b0;

    always @(posedge clk) begin
        m_live <= 1'b1;
        if (rst) begin
            m_since <= -1;
            m_p     <= '0;
        end else if (m_since < 0) begin
            if (v4) begin
                m_since <= 0;
                m_pend  <= 8'(a4) * 8'(b4);
            end
        end else if (m_since == 4) begin
            m_since <= -1;
        end else begin
            m_since <= m_since + 1;
            if (m_since == 3) m_p <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_ready",   r4,  (m_since < 0) ? 1 : 0);
            check("model_o_valid", ov4, (m_since == 4) ? 1 : 0);
            check("model_P",       p4,  m_p);
        end
    end

    task automatic drive(input int w, input logic [7:0] a, input logic [7:0] b, input logic v);
        case (w)
            4:       begin a4 = a[3:0]; b4 = b[3:0]; v4 = v; end
            8:       begin a8 = a;      b8 = b;      v8 = v; end
            default: begin a1 = a[0:0]; b1 = b[0:0]; v1 = v; end
        endcase
    endtask

    function automatic logic get_ready(input int w);
        case (w)
            4:       return r4;
            8:       return r8;
            default: return r1;
        endcase
    endfunction

    function automatic logic get_ov(input int w);
        case (w)
            4:       return ov4;
            8:       return ov8;
            default: return ov1;
        endcase
    endfunction

    function automatic logic [15:0] get_p(input int w);
        case (w)
            4:       return {8'b0, p4};
            8:       return p8;
            default: return {14'b0, p1};
        endcase
    endfunction

    // One request from idle; reports product, accept-to-result latency in cycles
    // and how many cycles ready stayed low.
    task automatic do_req(input int w, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] p, output int lat, output int busy);
        @(negedge clk) drive(w, a, b, 1'b1);
        @(negedge clk) drive(w, a, b, 1'b0);
        lat  = 1;
        busy = get_ready(w) ? 0 : 1;
        while (!get_ov(w) && lat < 40) begin
            @(negedge clk);
            lat++;
            if (!get_ready(w)) busy++;
        end
        if (!get_ov(w)) check("o_valid_timeout", 0, 1);
        p = get_p(w);
        @(negedge clk);
        check("o_valid_single_pulse", get_ov(w), 0);
        check("ready_after_done", get_ready(w), 1);
    endtask

    logic [15:0] p;
    int lat, busy, n, pulses;

    initial begin
        // i_valid held high through reset must not be taken.
        drive(4, 8'd15, 8'd15, 1'b1);
        drive(8, 8'd9, 8'd9, 1'b1);
        drive(1, 8'd1, 8'd1, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_ready4", r4, 1);
        check("rst_ovalid4", ov4, 0);
        check("rst_p4", p4, 0);
        check("rst_ready8", r8, 1);
        check("rst_p8", p8, 0);
        check("rst_ready1", r1, 1);
        drive(8, 8'd0, 8'd0, 1'b0);
        drive(1, 8'd0, 8'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("first_accept_after_rst", r4, 0);
        drive(4, 8'd0, 8'd0, 1'b0);
        n = 0;
        while (!ov4 && n < 40) begin @(negedge clk); n++; end
        check("first_after_rst_P", p4, 225);
        @(negedge clk);

        do_req(4, 8'd15, 8'd15, p, lat, busy);
        check("w4_15x15_P", p, 16'hE1);
        check("w4_15x15_latency", lat, 5);
        check("w4_15x15_ready_low", busy, 5);

        do_req(4, 8'd0, 8'd9, p, lat, busy);
        check("w4_0x9_P", p, 0);
        check("w4_0x9_latency", lat, 5);

        // i_valid stays high with new operands through BUSY/DONE.
        @(negedge clk) drive(4, 8'd3, 8'd5, 1'b1);
        @(negedge clk) drive(4, 8'd7, 8'd7, 1'b1);
        n = 0;
        while (!ov4 && n < 40) begin @(negedge clk); n++; end
        check("held_first_P", p4, 15);
        n = 0;
        while (!r4 && n < 40) begin @(negedge clk); n++; end
        @(negedge clk) drive(4, 8'd7, 8'd7, 1'b0);
        check("held_second_accept", r4, 0);
        n = 0;
        while (!ov4 && n < 40) begin @(negedge clk); n++; end
        check("held_second_P", p4, 49);
        @(negedge clk);

        // Abort in the second BUSY cycle.
        @(negedge clk) drive(4, 8'd12, 8'd11, 1'b1);
        @(negedge clk) drive(4, 8'd12, 8'd11, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_ready", r4, 1);
        check("abort_P", p4, 0);
        pulses = 0;
        repeat (12) begin @(negedge clk); if (ov4) pulses++; end
        check("abort_no_o_valid", pulses, 0);
        do_req(4, 8'd2, 8'd3, p, lat, busy);
        check("after_abort_P", p, 6);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_req(4, 8'(a), 8'(b), p, lat, busy);
                check("sweep_P", p, a * b);
            end
        end

        do_req(8, 8'd255, 8'd255, p, lat, busy);
        check("w8_255x255_P", p, 16'hFE01);
        check("w8_latency", lat, 9);
        check("w8_ready_low", busy, 9);
        do_req(8, 8'd200, 8'd3, p, lat, busy);
        check("w8_200x3_P", p, 600);

        do_req(1, 8'd1, 8'd1, p, lat, busy);
        check("w1_1x1_P", p, 1);
        check("w1_latency", lat, 2);
        check("w1_ready_low", busy, 2);
        do_req(1, 8'd1, 8'd0, p, lat, busy);
        check("w1_1x0_P", p, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
